// File: rtl/arc4_pkg.sv
// ARC4 shared definitions: widths, S-memory depth and the encrypt FSM states.
// Imported by encrypt and s_mem.
package arc4_pkg;

   localparam int KEY_W     = 24;
   localparam int ADDR_W    = 8;
   localparam int MEM_DEPTH = 256;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_RI,
      ST_KSA_RJ,
      ST_KSA_WI,
      ST_KSA_WJ,
      ST_LEN_RD,
      ST_LEN_WR,
      ST_PRG_RI,
      ST_PRG_RJ,
      ST_PRG_WI,
      ST_PRG_WJ,
      ST_PRG_RP,
      ST_PRG_CT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/s_mem.sv
// 256x8 single-port RAM holding the ARC4 S permutation.
// Ports: clk, addr, wrdata, wren; rddata is registered (1-cycle latency).
module s_mem
   import arc4_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] wrdata,
   input  logic              wren,
   output logic [ADDR_W-1:0] rddata
);

   logic [ADDR_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (wren)
         mem[addr] <= wrdata;
      rddata <= mem[addr];
   end

endmodule

// File: rtl/encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, writes ciphertext.
// Ports: clk, rst (sync, high), en/rdy start handshake, key, pt_* read, ct_* write.
module encrypt
   import arc4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   input  logic [KEY_W-1:0]  key,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [ADDR_W-1:0] pt_rddata,
   output logic [ADDR_W-1:0] ct_addr,
   output logic [ADDR_W-1:0] ct_wrdata,
   output logic              ct_wren
);

   state_t state, state_d;

   logic [KEY_W-1:0]  key_q;
   logic [ADDR_W-1:0] i, j, k, len, si, sj;
   logic [1:0]        km;

   logic [ADDR_W-1:0] s_addr, s_wdata, s_rd;
   logic              s_wren;
   logic [ADDR_W-1:0] kb, i_inc, j_ksa, j_prg;

   s_mem u_s_mem (
      .clk    (clk),
      .addr   (s_addr),
      .wrdata (s_wdata),
      .wren   (s_wren),
      .rddata (s_rd)
   );

   // key byte i mod 3, tracked by a wrapping 0..2 counter
   always_comb begin
      kb = key_q[7:0];
      unique case (km)
         2'd0:    kb = key_q[23:16];
         2'd1:    kb = key_q[15:8];
         default: kb = key_q[7:0];
      endcase
   end

   assign i_inc = i + 8'd1;
   assign j_ksa = j + s_rd + kb;
   assign j_prg = j + s_rd;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d   = state;
      rdy       = 1'b0;
      pt_addr   = '0;
      ct_addr   = '0;
      ct_wrdata = '0;
      ct_wren   = 1'b0;
      s_addr    = i;
      s_wdata   = i;
      s_wren    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en)
               state_d = ST_INIT;
         end
         ST_INIT: begin
            s_wren = 1'b1;
            if (i == 8'hff)
               state_d = ST_KSA_RI;
         end
         ST_KSA_RI: state_d = ST_KSA_RJ;
         ST_KSA_RJ: begin
            s_addr  = j_ksa;
            state_d = ST_KSA_WI;
         end
         ST_KSA_WI: begin
            s_wdata = s_rd;
            s_wren  = 1'b1;
            state_d = ST_KSA_WJ;
         end
         ST_KSA_WJ: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
            state_d = (i == 8'hff) ? ST_LEN_RD : ST_KSA_RI;
         end
         ST_LEN_RD: state_d = ST_LEN_WR;
         ST_LEN_WR: begin
            ct_wren   = 1'b1;
            ct_wrdata = pt_rddata;
            state_d   = (pt_rddata == 8'd0) ? ST_DONE : ST_PRG_RI;
         end
         ST_PRG_RI: begin
            s_addr  = i_inc;
            pt_addr = k;
            state_d = ST_PRG_RJ;
         end
         ST_PRG_RJ: begin
            s_addr  = j_prg;
            pt_addr = k;
            state_d = ST_PRG_WI;
         end
         ST_PRG_WI: begin
            s_wdata = s_rd;
            s_wren  = 1'b1;
            pt_addr = k;
            state_d = ST_PRG_WJ;
         end
         ST_PRG_WJ: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
            pt_addr = k;
            state_d = ST_PRG_RP;
         end
         // after the swap S[i]+S[j] equals the pre-swap sum
         ST_PRG_RP: begin
            s_addr  = si + sj;
            pt_addr = k;
            state_d = ST_PRG_CT;
         end
         ST_PRG_CT: begin
            pt_addr   = k;
            ct_wren   = 1'b1;
            ct_addr   = k;
            ct_wrdata = pt_rddata ^ s_rd;
            state_d   = (k == len) ? ST_DONE : ST_PRG_RI;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         len   <= '0;
         si    <= '0;
         sj    <= '0;
         km    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (en) begin
                  key_q <= key;
                  i     <= '0;
                  j     <= '0;
                  km    <= '0;
               end
            end
            ST_INIT: i <= i_inc;
            ST_KSA_RJ: begin
               j  <= j_ksa;
               si <= s_rd;
            end
            ST_KSA_WJ: begin
               i  <= i_inc;
               km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
               if (i == 8'hff)
                  j <= '0;
            end
            ST_LEN_WR: begin
               len <= pt_rddata;
               k   <= 8'd1;
            end
            ST_PRG_RI: i <= i_inc;
            ST_PRG_RJ: begin
               j  <= j_prg;
               si <= s_rd;
            end
            ST_PRG_WI: sj <= s_rd;
            ST_PRG_CT: k <= k + 8'd1;
            default: ;
         endcase
      end
   end

endmodule
